prim_shadow_wr_seq: RTL and testbench

Sequencer that performs complete shadowed-register updates on behalf of several hardware requesters sharing one shadowed register bank port. A round-robin arbiter picks one requester. The sequencer then issues a phase-clearing read, two identical writes and an integrity check, and returns a status. It sits between on-chip hardware masters (key managers, config loaders) and the shadowed register bank, so each master can treat a shadowed update as a single transaction.

---
 rtl/prim_shadow_wr_seq_pkg.sv | 20 ++
 rtl/prim_shadow_wr_seq_rr_arb.sv | 48 ++++
 rtl/prim_shadow_wr_seq.sv | 148 ++++++++++++++
 tb/tb_prim_shadow_wr_seq.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prim_shadow_wr_seq_pkg.sv
// Shared types for the shadowed-register write sequencer.
package prim_shadow_wr_seq_pkg;

  typedef enum logic [2:0] {
    Idle  = 3'd0,
    Clear = 3'd1,
    Wr1   = 3'd2,
    Wr2   = 3'd3,
    Check = 3'd4,
    Resp  = 3'd5
  } seq_state_e;

  typedef enum logic [1:0] {
    RspOk     = 2'd0,
    RspUpdErr = 2'd1,
    RspStoErr = 2'd2,
    RspLocked = 2'd3
  } rsp_err_e;

endpackage

// File: rtl/prim_shadow_wr_seq_rr_arb.sv
// Round-robin arbiter: first asserted request at or after the pointer wins.
module prim_shadow_wr_seq_rr_arb #(
  parameter  int NumReq = 4,
  localparam int IdW    = $clog2(NumReq)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumReq-1:0] req,
  input  logic              advance,
  output logic [NumReq-1:0] gnt,
  output logic [IdW-1:0]    idx
);

  logic [IdW-1:0] ptr_q;
  logic [IdW-1:0] cand;
  logic           found;
  int unsigned    pos;

  // Search upward from the pointer with wrap, stopping at the first request.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < unsigned'(NumReq); i++) begin
      pos = 32'(ptr_q) + i;
      if (pos >= unsigned'(NumReq)) pos = pos - unsigned'(NumReq);
      cand = IdW'(pos);
      if (!found && req[cand]) begin
        found     = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

  // Pointer moves just past the winner whenever a grant is taken.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (advance) begin
      if (idx == IdW'(NumReq - 1)) ptr_q <= '0;
      else                         ptr_q <= idx + 1'b1;
    end
  end

endmodule

// File: rtl/prim_shadow_wr_seq.sv
// Shadowed-register update sequencer: clear read, two writes, integrity check, response.
module prim_shadow_wr_seq
  import prim_shadow_wr_seq_pkg::*;
#(
  parameter  int NumReq = 4,
  parameter  int DW     = 32,
  parameter  int AW     = 8,
  localparam int IdW    = $clog2(NumReq)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NumReq-1:0]    req_i,
  input  logic [NumReq*AW-1:0] addr_i,
  input  logic [NumReq*DW-1:0] wdata_i,
  output logic [NumReq-1:0]    gnt_o,
  output logic                 rsp_valid_o,
  output logic [IdW-1:0]       rsp_id_o,
  output logic [1:0]           rsp_err_o,
  output logic [AW-1:0]        reg_addr_o,
  output logic                 reg_re_o,
  output logic                 reg_we_o,
  output logic [DW-1:0]        reg_wd_o,
  input  logic                 reg_err_update_i,
  input  logic                 reg_err_storage_i,
  output logic                 fatal_o
);

  seq_state_e        state_q, state_d;
  logic [AW-1:0]     addr_q;
  logic [DW-1:0]     data_q;
  logic [IdW-1:0]    id_q;
  logic              upd_err_q, sto_err_q, locked_q, fatal_q;

  logic [NumReq-1:0] arb_gnt;
  logic [IdW-1:0]    arb_idx;
  logic              grant_en;
  logic [AW-1:0]     sel_addr;
  logic [DW-1:0]     sel_data;

  // Grants are only taken in Idle; rst_ni gating keeps gnt_o low while reset is held.
  assign grant_en = rst_ni && (state_q == Idle) && (|req_i);
  assign gnt_o    = grant_en ? arb_gnt : '0;
  assign fatal_o  = fatal_q;

  prim_shadow_wr_seq_rr_arb #(
    .NumReq (NumReq)
  ) u_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req     (req_i),
    .advance (grant_en),
    .gnt     (arb_gnt),
    .idx     (arb_idx)
  );

  // Pick the winner's address and data out of the flattened request buses.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < unsigned'(NumReq); i++) begin
      if (arb_idx == IdW'(i)) begin
        sel_addr = addr_i[i*AW +: AW];
        sel_data = wdata_i[i*DW +: DW];
      end
    end
  end

  // State register plus captured transaction context and error flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= Idle;
      addr_q    <= '0;
      data_q    <= '0;
      id_q      <= '0;
      upd_err_q <= 1'b0;
      sto_err_q <= 1'b0;
      locked_q  <= 1'b0;
      fatal_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_en) begin
        addr_q    <= sel_addr;
        data_q    <= sel_data;
        id_q      <= arb_idx;
        locked_q  <= fatal_q;
        upd_err_q <= 1'b0;
        sto_err_q <= 1'b0;
      end
      if (state_q == Wr2) upd_err_q <= reg_err_update_i;
      if (state_q == Check) begin
        sto_err_q <= reg_err_storage_i;
        if (reg_err_storage_i) fatal_q <= 1'b1;
      end
    end
  end

  // Next-state and bank/response outputs.
  always_comb begin
    state_d     = state_q;
    reg_re_o    = 1'b0;
    reg_we_o    = 1'b0;
    reg_addr_o  = '0;
    reg_wd_o    = '0;
    rsp_valid_o = 1'b0;
    rsp_id_o    = '0;
    rsp_err_o   = RspOk;
    unique case (state_q)
      Idle: begin
        // A locked bank skips the bank sequence entirely.
        if (grant_en) state_d = fatal_q ? Resp : Clear;
      end
      Clear: begin
        reg_re_o   = 1'b1;
        reg_addr_o = addr_q;
        reg_wd_o   = data_q;
        state_d    = Wr1;
      end
      Wr1: begin
        reg_we_o   = 1'b1;
        reg_addr_o = addr_q;
        reg_wd_o   = data_q;
        state_d    = Wr2;
      end
      Wr2: begin
        reg_we_o   = 1'b1;
        reg_addr_o = addr_q;
        reg_wd_o   = data_q;
        state_d    = Check;
      end
      Check: begin
        reg_addr_o = addr_q;
        reg_wd_o   = data_q;
        state_d    = Resp;
      end
      Resp: begin
        rsp_valid_o = 1'b1;
        rsp_id_o    = id_q;
        if (locked_q)       rsp_err_o = RspLocked;
        else if (sto_err_q) rsp_err_o = RspStoErr;
        else if (upd_err_q) rsp_err_o = RspUpdErr;
        else                rsp_err_o = RspOk;
        state_d = Idle;
      end
      default: state_d = Idle;
    endcase
  end

endmodule

// File: tb/tb_prim_shadow_wr_seq.sv
// Directed self-checking bench for the shadowed-register write sequencer.
module tb_prim_shadow_wr_seq;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [3:0]  req_i = '0;
  logic [31:0] addr_i = '0;
  logic [127:0] wdata_i = '0;
  logic [3:0]  gnt_o;
  logic        rsp_valid_o;
  logic [1:0]  rsp_id_o;
  logic [1:0]  rsp_err_o;
  logic [7:0]  reg_addr_o;
  logic        reg_re_o;
  logic        reg_we_o;
  logic [31:0] reg_wd_o;
  logic        reg_err_update_i = 1'b0;
  logic        reg_err_storage_i = 1'b0;
  logic        fatal_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  prim_shadow_wr_seq #(
    .NumReq (4),
    .DW     (32),
    .AW     (8)
  ) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .req_i             (req_i),
    .addr_i            (addr_i),
    .wdata_i           (wdata_i),
    .gnt_o             (gnt_o),
    .rsp_valid_o       (rsp_valid_o),
    .rsp_id_o          (rsp_id_o),
    .rsp_err_o         (rsp_err_o),
    .reg_addr_o        (reg_addr_o),
    .reg_re_o          (reg_re_o),
    .reg_we_o          (reg_we_o),
    .reg_wd_o          (reg_wd_o),
    .reg_err_update_i  (reg_err_update_i),
    .reg_err_storage_i (reg_err_storage_i),
    .fatal_o           (fatal_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    req_i  = '0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  // Drives one request from Idle and records six cycles (T..T+5) of DUT activity.
  task automatic drive_txn(input int r, input logic [7:0] a, input logic [31:0] d,
                           input logic upd, input logic sto,
                           output logic [3:0] g, output logic [5:0] re_t,
                           output logic [5:0] we_t, output logic [5:0] rv_t,
                           output logic [1:0] err, output logic [1:0] id,
                           output logic [7:0] addr_t1, output logic [31:0] wd_t2,
                           output logic [31:0] wd_t3);
    req_i = '0;
    req_i[r] = 1'b1;
    addr_i[r*8 +: 8]   = a;
    wdata_i[r*32 +: 32] = d;
    err = '0; id = '0; addr_t1 = '0; wd_t2 = '0; wd_t3 = '0;
    #1;
    g = gnt_o;
    re_t[0] = reg_re_o; we_t[0] = reg_we_o; rv_t[0] = rsp_valid_o;
    for (int c = 1; c < 6; c++) begin
      step();
      if (c == 1) req_i = '0;
      reg_err_update_i  = upd && (c == 3);
      reg_err_storage_i = sto && (c == 4);
      #1;
      re_t[c] = reg_re_o; we_t[c] = reg_we_o; rv_t[c] = rsp_valid_o;
      if (c == 1) addr_t1 = reg_addr_o;
      if (c == 2) wd_t2 = reg_wd_o;
      if (c == 3) wd_t3 = reg_wd_o;
      if (rsp_valid_o) begin err = rsp_err_o; id = rsp_id_o; end
    end
    step();
    reg_err_update_i  = 1'b0;
    reg_err_storage_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    req_i  = 4'b1111;
    #3;
    checks++;
    if ({gnt_o, rsp_valid_o, rsp_id_o, rsp_err_o, reg_addr_o, reg_re_o, reg_we_o, reg_wd_o, fatal_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b rv=%b id=%0d err=%0d addr=%h re=%b we=%b wd=%h fatal=%b, required all 0",
               gnt_o, rsp_valid_o, rsp_id_o, rsp_err_o, reg_addr_o, reg_re_o, reg_we_o, reg_wd_o, fatal_o);
    end
    do_reset();
  endtask

  task automatic test_single();
    logic [3:0] g; logic [5:0] re_t, we_t, rv_t; logic [1:0] err, id;
    logic [7:0] a1; logic [31:0] w2, w3;
    drive_txn(2, 8'h10, 32'hDEADBEEF, 1'b0, 1'b0, g, re_t, we_t, rv_t, err, id, a1, w2, w3);
    checks++;
    if (g !== 4'b0100) begin errors++; $display("FAIL single_gnt: got %b want 0100", g); end
    checks++;
    if (re_t !== 6'b000010) begin errors++; $display("FAIL single_re_trace: got %b want 000010", re_t); end
    checks++;
    if (we_t !== 6'b001100) begin errors++; $display("FAIL single_we_trace: got %b want 001100", we_t); end
    checks++;
    if (rv_t !== 6'b100000) begin errors++; $display("FAIL single_rv_trace: got %b want 100000", rv_t); end
    checks++;
    if (a1 !== 8'h10) begin errors++; $display("FAIL single_addr: got %h want 10", a1); end
    checks++;
    if (w2 !== 32'hDEADBEEF || w3 !== 32'hDEADBEEF) begin
      errors++; $display("FAIL single_wdata: got %h/%h want deadbeef", w2, w3);
    end
    checks++;
    if (id !== 2'd2 || err !== 2'd0) begin errors++; $display("FAIL single_rsp: id=%0d err=%0d want id=2 err=0", id, err); end
    checks++;
    if (reg_addr_o !== 8'h00 || reg_wd_o !== 32'h0) begin
      errors++; $display("FAIL single_idle_bus: addr=%h wd=%h want 0", reg_addr_o, reg_wd_o);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    req_i = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++;
      if (gnt_o !== (4'b0001 << (k % 4))) begin
        errors++; $display("FAIL rr_gnt_%0d: got %b want %b", k, gnt_o, 4'b0001 << (k % 4));
      end
      for (int c = 1; c < 6; c++) begin
        step();
        if (k == 7 && c == 1) req_i = '0;
        if (c == 3) begin
          checks++;
          if (gnt_o !== 4'b0000) begin errors++; $display("FAIL rr_busy_gnt_%0d: got %b want 0000", k, gnt_o); end
        end
        if (c == 5) begin
          checks++;
          if (rsp_valid_o !== 1'b1 || rsp_id_o !== 2'(k % 4)) begin
            errors++; $display("FAIL rr_rsp_%0d: rv=%b id=%0d want rv=1 id=%0d", k, rsp_valid_o, rsp_id_o, k % 4);
          end
        end
      end
      step();
    end
  endtask

  task automatic test_upd_err();
    logic [3:0] g; logic [5:0] re_t, we_t, rv_t; logic [1:0] err, id;
    logic [7:0] a1; logic [31:0] w2, w3;
    drive_txn(0, 8'h20, 32'h12345678, 1'b1, 1'b0, g, re_t, we_t, rv_t, err, id, a1, w2, w3);
    checks++;
    if (err !== 2'd1 || id !== 2'd0) begin errors++; $display("FAIL upd_err_rsp: err=%0d id=%0d want err=1 id=0", err, id); end
    checks++;
    if (fatal_o !== 1'b0) begin errors++; $display("FAIL upd_err_fatal: got %b want 0", fatal_o); end
    drive_txn(1, 8'h21, 32'h0BADF00D, 1'b0, 1'b0, g, re_t, we_t, rv_t, err, id, a1, w2, w3);
    checks++;
    if (g !== 4'b0010 || err !== 2'd0 || id !== 2'd1) begin
      errors++; $display("FAIL upd_err_next: gnt=%b err=%0d id=%0d want gnt=0010 err=0 id=1", g, err, id);
    end
  endtask

  task automatic test_sto_err();
    logic [3:0] g; logic [5:0] re_t, we_t, rv_t; logic [1:0] err, id;
    logic [7:0] a1; logic [31:0] w2, w3;
    drive_txn(2, 8'h30, 32'hCAFEF00D, 1'b1, 1'b1, g, re_t, we_t, rv_t, err, id, a1, w2, w3);
    checks++;
    if (err !== 2'd2 || id !== 2'd2) begin errors++; $display("FAIL sto_err_rsp: err=%0d id=%0d want err=2 id=2", err, id); end
    checks++;
    if (fatal_o !== 1'b1) begin errors++; $display("FAIL sto_err_fatal: got %b want 1", fatal_o); end
    drive_txn(1, 8'h31, 32'h11112222, 1'b0, 1'b0, g, re_t, we_t, rv_t, err, id, a1, w2, w3);
    checks++;
    if (g !== 4'b0010) begin errors++; $display("FAIL locked_gnt: got %b want 0010", g); end
    checks++;
    if (re_t !== 6'b0 || we_t !== 6'b0) begin errors++; $display("FAIL locked_strobes: re=%b we=%b want 0", re_t, we_t); end
    checks++;
    if (rv_t !== 6'b000010 || err !== 2'd3 || id !== 2'd1) begin
      errors++; $display("FAIL locked_rsp: rv=%b err=%0d id=%0d want rv=000010 err=3 id=1", rv_t, err, id);
    end
    checks++;
    if (fatal_o !== 1'b1) begin errors++; $display("FAIL locked_fatal_sticky: got %b want 1", fatal_o); end
  endtask

  task automatic test_mid_reset();
    logic [3:0] g; logic [5:0] re_t, we_t, rv_t; logic [1:0] err, id;
    logic [7:0] a1; logic [31:0] w2, w3;
    int rv_seen;
    do_reset();
    addr_i[7:0] = 8'h40; wdata_i[31:0] = 32'hA5A5A5A5;
    req_i = 4'b1001;
    #1;
    checks++;
    if (gnt_o !== 4'b0001) begin errors++; $display("FAIL midrst_gnt0: got %b want 0001", gnt_o); end
    step();
    req_i = 4'b1000;
    step();
    checks++;
    if (reg_we_o !== 1'b1) begin errors++; $display("FAIL midrst_wr1: we=%b want 1", reg_we_o); end
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({gnt_o, rsp_valid_o, rsp_id_o, rsp_err_o, reg_addr_o, reg_re_o, reg_we_o, reg_wd_o, fatal_o} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: gnt=%b rv=%b addr=%h re=%b we=%b wd=%h fatal=%b, required all 0",
               gnt_o, rsp_valid_o, reg_addr_o, reg_re_o, reg_we_o, reg_wd_o, fatal_o);
    end
    rv_seen = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (rsp_valid_o) rv_seen++;
    end
    checks++;
    if (rv_seen !== 0) begin errors++; $display("FAIL midrst_no_rsp: saw %0d responses want 0", rv_seen); end
    rst_ni = 1'b1;
    drive_txn(3, 8'h43, 32'h5A5A5A5A, 1'b0, 1'b0, g, re_t, we_t, rv_t, err, id, a1, w2, w3);
    checks++;
    if (g !== 4'b1000 || re_t !== 6'b000010 || we_t !== 6'b001100 || rv_t !== 6'b100000) begin
      errors++; $display("FAIL midrst_resume: gnt=%b re=%b we=%b rv=%b want 1000/000010/001100/100000", g, re_t, we_t, rv_t);
    end
    checks++;
    if (id !== 2'd3 || err !== 2'd0 || w2 !== 32'h5A5A5A5A || a1 !== 8'h43) begin
      errors++; $display("FAIL midrst_resume_rsp: id=%0d err=%0d wd=%h addr=%h want 3/0/5a5a5a5a/43", id, err, w2, a1);
    end
  endtask

  task automatic test_withdrawn();
    int g1_seen, rv_seen;
    g1_seen = 0; rv_seen = 0;
    req_i = 4'b0001;
    #1;
    checks++;
    if (gnt_o !== 4'b0001) begin errors++; $display("FAIL wd_gnt0: got %b want 0001", gnt_o); end
    for (int c = 1; c < 13; c++) begin
      step();
      if (c == 1) req_i = 4'b0010;
      if (c == 4) req_i = 4'b0000;
      #1;
      if (gnt_o[1]) g1_seen++;
      if (rsp_valid_o) begin
        rv_seen++;
        checks++;
        if (rsp_id_o !== 2'd0) begin errors++; $display("FAIL wd_rsp_id: got %0d want 0", rsp_id_o); end
      end
    end
    checks++;
    if (g1_seen !== 0) begin errors++; $display("FAIL wd_no_grant: req1 granted %0d times want 0", g1_seen); end
    checks++;
    if (rv_seen !== 1) begin errors++; $display("FAIL wd_rsp_count: got %0d want 1", rv_seen); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_upd_err();
    test_sto_err();
    test_mid_reset();
    test_withdrawn();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
